// File: rtl/shop_pkg.sv
// Shared definitions for the shop display path: converter FSM encoding and
// display-width constants.
package shop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DISP_DIGITS = 4;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAX_BCD_VAL = pow10(DISP_DIGITS) - 1;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// leading-zero blanking and saturation to all nines on overflow.
module bin2bcd_seq
  import shop_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank,
  output logic                overflow
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(IN_W + 1);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  state_t              r_state;
  state_t              w_next;
  logic [IN_W-1:0]     r_shreg;
  logic [BCD_W-1:0]    r_scratch;
  logic [BCD_W-1:0]    w_corr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_pend;
  logic [BCD_W-1:0]    r_bcd;
  logic [DIGITS-1:0]   r_blank;
  logic [DIGITS-1:0]   w_blank;
  logic                w_hi_zero;
  logic                r_ovf;
  logic                r_done;
  logic                w_accept;
  logic                w_last;

  function automatic logic [BCD_W-1:0] sat_bcd();
    return {DIGITS{4'h9}};
  endfunction

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == CNT_W'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_corr[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_SHIFT);
  end

  // Shift datapath: correct all digits from pre-correction values, then shift
  // {scratch, shreg} left so the input MSB enters scratch bit 0.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shreg    <= bin;
      r_scratch  <= '0;
      r_cnt      <= CNT_W'(IN_W);
      r_ovf_pend <= (32'(bin) > MAX_VAL);
    end else if (r_state == ST_SHIFT) begin
      r_scratch  <= {w_corr[BCD_W-2:0], r_shreg[IN_W-1]};
      r_shreg    <= r_shreg << 1;
      r_cnt      <= r_cnt - CNT_W'(1);
      r_ovf_pend <= r_ovf_pend | w_corr[BCD_W-1];
    end
  end

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = w_hi_zero;
    end
  end

  // Result stage: outputs only move on the done cycle, so the display never
  // sees partial scratch contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
      r_ovf   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        if (r_ovf_pend) begin
          r_bcd   <= sat_bcd();
          r_blank <= '0;
          r_ovf   <= 1'b1;
        end else begin
          r_bcd   <= r_scratch;
          r_blank <= w_blank;
          r_ovf   <= 1'b0;
        end
      end
    end
  end

  assign done     = r_done;
  assign bcd      = r_bcd;
  assign blank    = r_blank;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values,
// compared against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IN_W-1:0]   bin;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
  logic [3:0]        blank;
  logic              overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] hold_bcd;
  logic [3:0]  hold_blank;
  logic        hold_ovf;

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .blank    (blank),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_bcd(input int v);
    logic [15:0] m;
    if (v > 9999) return 16'h9999;
    m = '0;
    for (int i = 0; i < 4; i++) m[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return m;
  endfunction

  function automatic logic [3:0] m_blank(input int v);
    logic [3:0] b;
    if (v > 9999) return 4'b0000;
    b = '0;
    for (int i = 1; i < 4; i++) b[i] = (v < (10 ** i));
    return b;
  endfunction

  // mode: 0 normal, 1 start/bin glitch mid-shift, 2 reset mid-shift,
  // 3 normal but return on the done cycle so the next start is back-to-back.
  task automatic conv(input int v, input int mode);
    int busy_n;
    int done_at;
    int extra;
    start = 1'b1;
    bin   = v[IN_W-1:0];
    @(negedge clk);
    start   = 1'b0;
    bin     = IN_W'($urandom_range(0, 16383));
    busy_n  = 0;
    done_at = 0;
    for (int idx = 1; idx <= 40 && done_at == 0; idx++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = idx;
      end else begin
        if (idx == 15 && mode != 2) check("hold_bcd", 32'(bcd), 32'(hold_bcd));
        if (mode == 1 && idx == 5) begin start = 1'b1; bin = 14'd42; end
        if (mode == 1 && idx == 6) start = 1'b0;
        if (mode == 2 && idx == 8) rst = 1'b1;
        if (mode == 2 && idx == 9) rst = 1'b0;
        @(negedge clk);
      end
    end
    if (mode == 2) begin
      check("rst_no_done", 32'(done_at), 32'd0);
      check("rst_bcd", 32'(bcd), 32'h0000);
      check("rst_blank", 32'(blank), 32'b1110);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      hold_bcd   = 16'h0000;
      hold_blank = 4'b1110;
      hold_ovf   = 1'b0;
    end else begin
      check("latency", 32'(done_at), 32'd16);
      check("busy_cycles", 32'(busy_n), 32'd14);
      check("bcd", 32'(bcd), 32'(m_bcd(v)));
      check("blank", 32'(blank), 32'(m_blank(v)));
      check("ovf", 32'(overflow), 32'(v > 9999));
      hold_bcd   = m_bcd(v);
      hold_blank = m_blank(v);
      hold_ovf   = (v > 9999);
      if (mode != 3) begin
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        if (mode == 1) begin
          extra = 0;
          for (int k = 0; k < 20; k++) begin
            if (done || busy) extra++;
            @(negedge clk);
          end
          check("no_second_conv", 32'(extra), 32'd0);
          check("glitch_bcd_hold", 32'(bcd), 32'(hold_bcd));
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_bcd", 32'(bcd), 32'h0000);
    check("reset_blank", 32'(blank), 32'b1110);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    hold_bcd   = 16'h0000;
    hold_blank = 4'b1110;
    hold_ovf   = 1'b0;

    // Reset and start together: start must not be accepted.
    rst   = 1'b1;
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_wins_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("rst_wins_done", 32'(done), 32'd0);

    conv(1234, 0);
    conv(7, 0);
    conv(0, 0);
    conv(9999, 0);
    conv(10000, 0);
    conv(16383, 0);
    conv(305, 1);
    conv(1111, 0);
    conv(555, 2);
    conv(555, 0);
    conv(81, 3);
    conv(4096, 3);
    conv(60, 0);
    for (int r = 0; r < 24; r++) begin
      if (r % 3 == 0) conv(int'($urandom_range(0, 16383)), 0);
      else if (r % 3 == 1) conv(int'($urandom_range(0, 9999)), 0);
      else conv(int'($urandom_range(0, 99)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter with leading-zero blanking.
- Sits directly upstream of the seven-segment display driver. It converts an amount from the shop controller (price, inserted money, change) into per-digit BCD nibbles plus a blank mask.
- The display selector consumes those outputs per scanned digit.
- Converts one value per start request, one bit per clock, using a start/busy/done handshake.

Parameters:
- IN_W, 14, width of binary input.
- DIGITS, 4, number of BCD output digits. The output range is 0 to 10^DIGITS-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of bin; sampled only in IDLE.
- bin  in  IN_W  unsigned binary value; captured on the accepted start cycle.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  one-cycle pulse when bcd/blank/overflow update.
- bcd  out  4*DIGITS  BCD result; digit 0 (units) is in bits [3:0].
- blank  out  DIGITS  1 = digit is a leading zero and is suppressed; bit 0 is never set.
- overflow  out  1  last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (rst=1 at clk edge, regardless of state):
  - FSM goes to IDLE; busy=0, done=0, bcd=0, overflow=0.
  - blank = all ones except bit 0 (display shows "0").
  - Any conversion in progress is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches bin into a shift register and clears a DIGITS*4-bit scratch.
  - Loads bit counter = IN_W, sets busy=1, goes to SHIFT.
  - Latches ovf_pend = (bin > 10^DIGITS-1), compared at full IN_W width.
- SHIFT, one bit per cycle:
  - Each scratch nibble >= 5 gets +3. All nibbles are corrected in parallel from pre-correction values.
  - Then {scratch, shreg} shifts left by 1, so the bin MSB enters scratch bit 0.
  - Counter decrements. After the IN_W-th shift, go to DONE.
- DONE, exactly one cycle:
  - done=1, busy=0, outputs registered in this same cycle.
  - If ovf_pend: bcd = all digits 9, overflow=1, blank = 0.
  - Otherwise: bcd = scratch, overflow=0. blank[i]=1 iff digit i and every higher digit are 0, for i>=1; blank[0]=0.
  - Next state is IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+IN_W+1. For IN_W=14 that is 16 cycles start-to-done.
- Next start can be accepted the cycle after DONE. Minimum period is IN_W+2 cycles.
- Outputs bcd/blank/overflow hold their previous values until the next done. The display never sees intermediate scratch values.
- start while in SHIFT or DONE is ignored; it is neither queued nor accepted. A change of bin after capture has no effect.
- Simultaneous rst and start: rst wins, and start is not accepted.
- Width rule: IN_W must be <= ceil(DIGITS*log2(10))+1. Intermediate scratch needs no extra bits because overflow is handled by the saturation path.

Decomposition:
- Shared package (shop_pkg):
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - DISP_DIGITS constant.
  - MAX_BCD_VAL = 10^DIGITS-1.
- One natural sub-module, bcd_add3: combinational 4-bit "if >=5 add 3" corrector, instantiated DIGITS times via generate.
- The blank-mask priority logic stays inline.

Test Plan:
- Reset then idle, no start -> bcd=16'h0000, blank=4'b1110, busy=0, done=0, overflow=0.
- start with bin=1234 -> busy high 14 cycles, done pulse on cycle 16, bcd=16'h1234, blank=4'b0000.
- bin=7 then bin=0 (second start after done) -> bcd=16'h0007, blank=4'b1110; then bcd=16'h0000, blank=4'b1110.
- bin=9999 then bin=10000 and bin=16383 -> 16'h9999, overflow=0. Then 16'h9999, overflow=1, blank=0 for both of the latter values.
- bin=305, with start pulsed again mid-SHIFT and bin changed to 42 -> single done, bcd=16'h0305, blank=4'b1000, no second conversion.
- rst asserted at cycle 8 of a conversion of 555 -> done never pulses, outputs at reset values. Fresh start with 555 -> bcd=16'h0555, blank=4'b1000.
